clk_rst_seq: RTL and testbench

Power-up and recovery sequencer for the board clock/reset tree. It pulses the DCM and PLL resets, waits for each lock with timeout and retry, then releases the DDR2 and Wishbone domain resets in order with a programmable gap. It re-runs the sequence on loss of lock or on a soft-reset request, and reports status to a debug register.

---
 rtl/clk_rst_seq.sv | 247 ++++++++++++++++++++++++
 tb/tb_clk_rst_seq.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_rst_seq.sv
// clk_rst_seq: power-up / recovery sequencer for the board clock and reset tree.
// Pulses DCM and PLL resets, waits for each lock (timeout + retry), then
// releases DDR2 and Wishbone domain resets in order with a programmable gap.
// Loss of lock or a soft reset request restarts the sequence.
//
// Ports:
//   sys_clk_pad_i  free-running board clock
//   rst_n_pad_i    async active-low reset
//   dcm_locked_i   DCM LOCKED (async, synchronised here)
//   pll_locked_i   PLL LOCKED (async, synchronised here)
//   soft_rst_i     one-cycle synchronous restart request
//   dcm_rst_o      DCM reset, active high
//   pll_rst_o      PLL reset, active high
//   ddr2_rst_o     DDR2 domain reset, active high
//   wb_rst_o       Wishbone domain reset, active high
//   ready_o        all domains out of reset
//   fail_o         retries exhausted, sticky until reset/soft reset
//   state_o        current state encoding
//   retry_cnt_o    timeouts since last RUN
//   lockloss_cnt_o lock-loss events, saturating
module clk_rst_seq #(
  parameter int unsigned RST_PULSE_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT     = 65535,
  parameter int unsigned RELEASE_GAP      = 16,
  parameter int unsigned MAX_RETRIES      = 7,
  parameter int unsigned CNT_W            = 16
) (
  input  logic       sys_clk_pad_i,
  input  logic       rst_n_pad_i,
  input  logic       dcm_locked_i,
  input  logic       pll_locked_i,
  input  logic       soft_rst_i,
  output logic       dcm_rst_o,
  output logic       pll_rst_o,
  output logic       ddr2_rst_o,
  output logic       wb_rst_o,
  output logic       ready_o,
  output logic       fail_o,
  output logic [2:0] state_o,
  output logic [3:0] retry_cnt_o,
  output logic [7:0] lockloss_cnt_o
);

  localparam int unsigned STATE_W = 3;
  localparam int unsigned RETRY_W = 4;
  localparam int unsigned LOSS_W  = 8;

  localparam logic [2:0] ST_PULSE    = 3'd0;
  localparam logic [2:0] ST_WAIT_DCM = 3'd1;
  localparam logic [2:0] ST_WAIT_PLL = 3'd2;
  localparam logic [2:0] ST_DDR_REL  = 3'd3;
  localparam logic [2:0] ST_WB_REL   = 3'd4;
  localparam logic [2:0] ST_RUN      = 3'd5;
  localparam logic [2:0] ST_FAIL     = 3'd6;

  localparam logic [CNT_W-1:0]   PULSE_LAST   = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   GAP_LAST     = CNT_W'(RELEASE_GAP - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);
  localparam logic [LOSS_W-1:0]  LOSS_SAT     = '1;

  logic               dcm_meta, dcm_s, pll_meta, pll_s;
  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [LOSS_W-1:0]  loss_q, loss_d;
  logic               timeout, lock_lost;
  logic               dcm_rst_d, pll_rst_d, ddr2_rst_d, wb_rst_d, ready_d, fail_d;

  // Two-flop synchronisers for the asynchronous lock inputs
  always_ff @(posedge sys_clk_pad_i or negedge rst_n_pad_i) begin
    if (!rst_n_pad_i) begin
      dcm_meta <= 1'b0;
      dcm_s    <= 1'b0;
      pll_meta <= 1'b0;
      pll_s    <= 1'b0;
    end else begin
      dcm_meta <= dcm_locked_i;
      dcm_s    <= dcm_meta;
      pll_meta <= pll_locked_i;
      pll_s    <= pll_meta;
    end
  end

  // Next state, counters and output decode of the state being entered
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    retry_d   = retry_q;
    loss_d    = loss_q;
    timeout   = 1'b0;
    lock_lost = 1'b0;

    case (state_q)
      ST_PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          state_d = ST_WAIT_DCM;
          cnt_d   = '0;
        end
      end
      ST_WAIT_DCM: begin
        if (dcm_s) begin
          state_d = ST_WAIT_PLL;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          timeout = 1'b1;
        end
      end
      ST_WAIT_PLL: begin
        if (!dcm_s) begin
          lock_lost = 1'b1;
        end else if (pll_s) begin
          state_d = ST_DDR_REL;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          timeout = 1'b1;
        end
      end
      ST_DDR_REL: begin
        if (!dcm_s || !pll_s) begin
          lock_lost = 1'b1;
        end else if (cnt_q == GAP_LAST) begin
          state_d = ST_WB_REL;
          cnt_d   = '0;
        end
      end
      ST_WB_REL: begin
        cnt_d = '0;
        if (!dcm_s || !pll_s) begin
          lock_lost = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q;
        if (!dcm_s || !pll_s) begin
          lock_lost = 1'b1;
        end
      end
      ST_FAIL: begin
        cnt_d = cnt_q;
      end
      default: begin
        state_d = ST_PULSE;
        cnt_d   = '0;
      end
    endcase

    // A timeout retries from PULSE until the retry budget is spent
    if (timeout) begin
      cnt_d = '0;
      if (retry_q < RETRY_MAX) begin
        retry_d = retry_q + RETRY_W'(1);
        state_d = ST_PULSE;
      end else begin
        state_d = ST_FAIL;
      end
    end

    if (lock_lost) begin
      state_d = ST_PULSE;
      cnt_d   = '0;
      if (loss_q != LOSS_SAT) begin
        loss_d = loss_q + LOSS_W'(1);
      end
    end

    if (state_d == ST_RUN) begin
      retry_d = '0;
    end

    // Soft reset overrides every other event in the same cycle
    if (soft_rst_i) begin
      state_d = ST_PULSE;
      cnt_d   = '0;
      retry_d = '0;
      loss_d  = loss_q;
    end

    dcm_rst_d  = 1'b1;
    pll_rst_d  = 1'b1;
    ddr2_rst_d = 1'b1;
    wb_rst_d   = 1'b1;
    ready_d    = 1'b0;
    fail_d     = 1'b0;
    case (state_d)
      ST_WAIT_DCM: dcm_rst_d = 1'b0;
      ST_WAIT_PLL: begin
        dcm_rst_d = 1'b0;
        pll_rst_d = 1'b0;
      end
      ST_DDR_REL: begin
        dcm_rst_d  = 1'b0;
        pll_rst_d  = 1'b0;
        ddr2_rst_d = 1'b0;
      end
      ST_WB_REL: begin
        dcm_rst_d  = 1'b0;
        pll_rst_d  = 1'b0;
        ddr2_rst_d = 1'b0;
        wb_rst_d   = 1'b0;
      end
      ST_RUN: begin
        dcm_rst_d  = 1'b0;
        pll_rst_d  = 1'b0;
        ddr2_rst_d = 1'b0;
        wb_rst_d   = 1'b0;
        ready_d    = 1'b1;
      end
      ST_FAIL: fail_d = 1'b1;
      default: ;
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge sys_clk_pad_i or negedge rst_n_pad_i) begin
    if (!rst_n_pad_i) begin
      state_q    <= ST_PULSE;
      cnt_q      <= '0;
      retry_q    <= '0;
      loss_q     <= '0;
      dcm_rst_o  <= 1'b1;
      pll_rst_o  <= 1'b1;
      ddr2_rst_o <= 1'b1;
      wb_rst_o   <= 1'b1;
      ready_o    <= 1'b0;
      fail_o     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      loss_q     <= loss_d;
      dcm_rst_o  <= dcm_rst_d;
      pll_rst_o  <= pll_rst_d;
      ddr2_rst_o <= ddr2_rst_d;
      wb_rst_o   <= wb_rst_d;
      ready_o    <= ready_d;
      fail_o     <= fail_d;
    end
  end

  assign state_o        = state_q;
  assign retry_cnt_o    = retry_q;
  assign lockloss_cnt_o = loss_q;

endmodule

// File: tb/tb_clk_rst_seq.sv
// tb_clk_rst_seq: directed test of clk_rst_seq with pulse=4, timeout=20,
// gap=3, retries=2. Expected values are hand-derived edge counts.
module tb_clk_rst_seq;

  logic       clk, rst_n, dcm_locked, pll_locked, soft_rst;
  logic       dcm_rst, pll_rst, ddr2_rst, wb_rst, ready, fail;
  logic [2:0] state;
  logic [3:0] retry_cnt;
  logic [7:0] lockloss_cnt;
  logic [5:0] flags;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_ll;

  // {dcm_rst, pll_rst, ddr2_rst, wb_rst, ready, fail}
  assign flags = {dcm_rst, pll_rst, ddr2_rst, wb_rst, ready, fail};

  clk_rst_seq #(
    .RST_PULSE_CYCLES(4),
    .LOCK_TIMEOUT    (20),
    .RELEASE_GAP     (3),
    .MAX_RETRIES     (2),
    .CNT_W           (16)
  ) dut (
    .sys_clk_pad_i (clk),
    .rst_n_pad_i   (rst_n),
    .dcm_locked_i  (dcm_locked),
    .pll_locked_i  (pll_locked),
    .soft_rst_i    (soft_rst),
    .dcm_rst_o     (dcm_rst),
    .pll_rst_o     (pll_rst),
    .ddr2_rst_o    (ddr2_rst),
    .wb_rst_o      (wb_rst),
    .ready_o       (ready),
    .fail_o        (fail),
    .state_o       (state),
    .retry_cnt_o   (retry_cnt),
    .lockloss_cnt_o(lockloss_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance n rising edges, then settle 1 time unit past the edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; dcm_locked = 1'b0; pll_locked = 1'b0; soft_rst = 1'b0;
    #2 rst_n = 1'b0;
    tick(3);
    checks++;
    if (flags !== 6'b111100) begin
      errors++; $display("FAIL reset_flags: got %b expected %b", flags, 6'b111100);
    end
    checks++;
    if (state !== 3'd0) begin
      errors++; $display("FAIL reset_state: got %0d expected 0", state);
    end
    checks++;
    if ({retry_cnt, lockloss_cnt} !== 12'd0) begin
      errors++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", retry_cnt, lockloss_cnt);
    end
  endtask

  // Edge c counted from reset release; dcm raised after edge 10, pll after 14
  task automatic test_power_up();
    logic [5:0] e;
    logic [2:0] es;
    rst_n = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      tick(1);
      e  = {c < 4, c < 13, c < 17, c < 20, c >= 21, 1'b0};
      es = (c < 4) ? 3'd0 : (c < 13) ? 3'd1 : (c < 17) ? 3'd2 :
           (c < 20) ? 3'd3 : (c == 20) ? 3'd4 : 3'd5;
      checks++;
      if (flags !== e) begin
        errors++; $display("FAIL power_up_flags edge %0d: got %b expected %b", c, flags, e);
      end
      checks++;
      if (state !== es) begin
        errors++; $display("FAIL power_up_state edge %0d: got %0d expected %0d", c, state, es);
      end
      checks++;
      if ((!wb_rst && ddr2_rst) || (!ddr2_rst && pll_rst) || (!pll_rst && dcm_rst)) begin
        errors++; $display("FAIL release_order edge %0d: got %b expected monotone release", c, flags);
      end
      if (c == 10) dcm_locked = 1'b1;
      if (c == 14) pll_locked = 1'b1;
    end
  endtask

  // One-cycle PLL drop in RUN; loss seen 3 edges later, relock 10 edges after that
  task automatic test_lock_loss();
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    tick(1);
    checks++;
    if (state !== 3'd5 || flags !== 6'b000010) begin
      errors++; $display("FAIL lockloss_early: got state %0d flags %b expected 5 000010", state, flags);
    end
    tick(1);
    checks++;
    if (state !== 3'd0 || flags !== 6'b111100) begin
      errors++; $display("FAIL lockloss_hit: got state %0d flags %b expected 0 111100", state, flags);
    end
    checks++;
    if (lockloss_cnt !== 8'd1 || retry_cnt !== 4'd0) begin
      errors++; $display("FAIL lockloss_count: got %0d/%0d expected 1/0", lockloss_cnt, retry_cnt);
    end
    tick(9);
    checks++;
    if (state !== 3'd4 || flags !== 6'b000000) begin
      errors++; $display("FAIL relock_wb_rel: got state %0d flags %b expected 4 000000", state, flags);
    end
    tick(1);
    checks++;
    if (state !== 3'd5 || flags !== 6'b000010) begin
      errors++; $display("FAIL relock_run: got state %0d flags %b expected 5 000010", state, flags);
    end
  endtask

  // DCM never locks: two retries then FAIL; soft reset recovers
  task automatic test_timeout_fail();
    dcm_locked = 1'b0; pll_locked = 1'b0; soft_rst = 1'b1;
    tick(1);
    soft_rst = 1'b0;
    checks++;
    if (state !== 3'd0 || flags !== 6'b111100 || lockloss_cnt !== 8'd1) begin
      errors++; $display("FAIL soft_from_run: got state %0d flags %b ll %0d expected 0 111100 1", state, flags, lockloss_cnt);
    end
    tick(4);
    checks++;
    if (state !== 3'd1 || flags !== 6'b011100) begin
      errors++; $display("FAIL wait_dcm_entry: got state %0d flags %b expected 1 011100", state, flags);
    end
    tick(19);
    checks++;
    if (state !== 3'd1) begin
      errors++; $display("FAIL timeout_boundary: got state %0d expected 1", state);
    end
    tick(1);
    checks++;
    if (state !== 3'd0 || retry_cnt !== 4'd1) begin
      errors++; $display("FAIL timeout_1: got state %0d retry %0d expected 0 1", state, retry_cnt);
    end
    tick(24);
    checks++;
    if (state !== 3'd0 || retry_cnt !== 4'd2) begin
      errors++; $display("FAIL timeout_2: got state %0d retry %0d expected 0 2", state, retry_cnt);
    end
    tick(24);
    checks++;
    if (state !== 3'd6 || flags !== 6'b111101 || retry_cnt !== 4'd2) begin
      errors++; $display("FAIL enter_fail: got state %0d flags %b retry %0d expected 6 111101 2", state, flags, retry_cnt);
    end
    tick(5);
    checks++;
    if (state !== 3'd6 || fail !== 1'b1) begin
      errors++; $display("FAIL fail_sticky: got state %0d fail %b expected 6 1", state, fail);
    end
    soft_rst = 1'b1;
    tick(1);
    soft_rst = 1'b0;
    checks++;
    if (state !== 3'd0 || flags !== 6'b111100 || retry_cnt !== 4'd0 || lockloss_cnt !== 8'd1) begin
      errors++; $display("FAIL soft_from_fail: got state %0d flags %b retry %0d ll %0d expected 0 111100 0 1", state, flags, retry_cnt, lockloss_cnt);
    end
  endtask

  // PLL lock becomes visible on exactly the WAIT_PLL timeout edge
  task automatic test_pll_at_timeout();
    dcm_locked = 1'b1;
    tick(5);
    checks++;
    if (state !== 3'd2 || flags !== 6'b001100) begin
      errors++; $display("FAIL wait_pll_entry: got state %0d flags %b expected 2 001100", state, flags);
    end
    tick(17);
    pll_locked = 1'b1;
    tick(2);
    checks++;
    if (state !== 3'd2) begin
      errors++; $display("FAIL wait_pll_last: got state %0d expected 2", state);
    end
    tick(1);
    checks++;
    if (state !== 3'd3 || flags !== 6'b000100 || retry_cnt !== 4'd0) begin
      errors++; $display("FAIL lock_on_timeout: got state %0d flags %b retry %0d expected 3 000100 0", state, flags, retry_cnt);
    end
  endtask

  // Soft reset, DCM loss and gap-done all land on the same edge in DDR_REL
  task automatic test_soft_priority();
    dcm_locked = 1'b0;
    tick(2);
    checks++;
    if (state !== 3'd3) begin
      errors++; $display("FAIL ddr_rel_hold: got state %0d expected 3", state);
    end
    soft_rst = 1'b1;
    tick(1);
    soft_rst = 1'b0;
    checks++;
    if (state !== 3'd0 || flags !== 6'b111100 || lockloss_cnt !== 8'd1) begin
      errors++; $display("FAIL soft_over_loss: got state %0d flags %b ll %0d expected 0 111100 1", state, flags, lockloss_cnt);
    end
    tick(1);
    checks++;
    if (state !== 3'd0 || lockloss_cnt !== 8'd1) begin
      errors++; $display("FAIL soft_after: got state %0d ll %0d expected 0 1", state, lockloss_cnt);
    end
  endtask

  // 256 PLL drops in DDR_REL; counter must stick at 255
  task automatic test_lockloss_saturate();
    exp_ll = 8'd1;
    dcm_locked = 1'b1;
    for (int i = 0; i < 256; i++) begin
      for (int k = 0; k < 100 && state !== 3'd3; k++) tick(1);
      checks++;
      if (state !== 3'd3) begin
        errors++; $display("FAIL sat_reach_ddr iter %0d: got state %0d expected 3", i, state);
      end
      pll_locked = 1'b0;
      for (int k = 0; k < 10 && state !== 3'd0; k++) tick(1);
      pll_locked = 1'b1;
      exp_ll = (exp_ll == 8'd255) ? 8'd255 : exp_ll + 8'd1;
      checks++;
      if (state !== 3'd0 || lockloss_cnt !== exp_ll) begin
        errors++; $display("FAIL sat_count iter %0d: got state %0d ll %0d expected 0 %0d", i, state, lockloss_cnt, exp_ll);
      end
    end
    checks++;
    if (lockloss_cnt !== 8'd255) begin
      errors++; $display("FAIL sat_final: got %0d expected 255", lockloss_cnt);
    end
  endtask

  // Reset asserted mid-cycle in WB_REL must clear outputs without an edge
  task automatic test_async_reset();
    for (int k = 0; k < 30 && state !== 3'd4; k++) tick(1);
    checks++;
    if (state !== 3'd4 || flags !== 6'b000000) begin
      errors++; $display("FAIL pre_async_wb_rel: got state %0d flags %b expected 4 000000", state, flags);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (flags !== 6'b111100 || state !== 3'd0) begin
      errors++; $display("FAIL async_reset_flags: got state %0d flags %b expected 0 111100", state, flags);
    end
    checks++;
    if ({retry_cnt, lockloss_cnt} !== 12'd0) begin
      errors++; $display("FAIL async_reset_counters: got %0d/%0d expected 0/0", retry_cnt, lockloss_cnt);
    end
    tick(2);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_lock_loss();
    test_timeout_fail();
    test_pll_at_timeout();
    test_soft_priority();
    test_lockloss_saturate();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
